// File: rtl/alu_out_arbiter.sv
// Round-robin arbiter sharing the FIFO_OUT write port between the ALU adder and
// multiplier result channels, with per-channel lockout and write counters.
module alu_out_arbiter #(
  parameter int FIFO_OUT_WIDTH = 25,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      a_valid_res,
  input  logic                      m_valid_res,
  input  logic [FIFO_OUT_WIDTH-1:0] result_add,
  input  logic [FIFO_OUT_WIDTH-1:0] result_mul,
  input  logic                      ready_f_res,
  output logic [FIFO_OUT_WIDTH-1:0] fifo_res,
  output logic                      w_en_out,
  output logic                      sum_written,
  output logic                      mul_written,
  output logic [CNT_WIDTH-1:0]      add_cnt,
  output logic [CNT_WIDTH-1:0]      mul_cnt
);

  typedef enum logic {
    CH_READY = 1'b0,
    CH_HOLD  = 1'b1
  } ch_state_t;

  typedef enum logic {
    SEL_ADD = 1'b0,
    SEL_MUL = 1'b1
  } sel_t;

  ch_state_t add_state_r;
  ch_state_t add_state_s;
  ch_state_t mul_state_r;
  ch_state_t mul_state_s;
  sel_t      last_grant_r;
  sel_t      last_grant_s;

  logic elig_a_s;
  logic elig_m_s;
  logic grant_a_s;
  logic grant_m_s;

  logic [FIFO_OUT_WIDTH-1:0] fifo_res_r;
  logic                      w_en_out_r;
  logic                      sum_written_r;
  logic                      mul_written_r;
  logic [CNT_WIDTH-1:0]      add_cnt_r;
  logic [CNT_WIDTH-1:0]      mul_cnt_r;

  // A granted channel stays locked until its valid is sampled low, so a result
  // whose producer is slow to drop valid is never written twice.
  function automatic ch_state_t next_ch_state(input ch_state_t cur,
                                              input logic      valid,
                                              input logic      grant);
    ch_state_t nxt;
    case (cur)
      CH_READY: begin
        if (grant) begin
          nxt = CH_HOLD;
        end else begin
          nxt = CH_READY;
        end
      end
      CH_HOLD: begin
        if (!valid) begin
          nxt = CH_READY;
        end else begin
          nxt = CH_HOLD;
        end
      end
      default: nxt = CH_READY;
    endcase
    return nxt;
  endfunction

  // Eligibility and round-robin grant decision
  always_comb begin
    elig_a_s  = a_valid_res & (add_state_r == CH_READY);
    elig_m_s  = m_valid_res & (mul_state_r == CH_READY);
    grant_a_s = 1'b0;
    grant_m_s = 1'b0;
    if (ready_f_res) begin
      case ({elig_a_s, elig_m_s})
        2'b10: grant_a_s = 1'b1;
        2'b01: grant_m_s = 1'b1;
        2'b11: begin
          if (last_grant_r == SEL_MUL) begin
            grant_a_s = 1'b1;
          end else begin
            grant_m_s = 1'b1;
          end
        end
        default: begin
          grant_a_s = 1'b0;
          grant_m_s = 1'b0;
        end
      endcase
    end else begin
      grant_a_s = 1'b0;
      grant_m_s = 1'b0;
    end
  end

  // Next-state for both channel FSMs and the round-robin pointer
  always_comb begin
    add_state_s  = next_ch_state(add_state_r, a_valid_res, grant_a_s);
    mul_state_s  = next_ch_state(mul_state_r, m_valid_res, grant_m_s);
    last_grant_s = last_grant_r;
    if (grant_a_s) begin
      last_grant_s = SEL_ADD;
    end else if (grant_m_s) begin
      last_grant_s = SEL_MUL;
    end else begin
      last_grant_s = last_grant_r;
    end
  end

  // Channel FSM and round-robin pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_state_r  <= CH_READY;
      mul_state_r  <= CH_READY;
      last_grant_r <= SEL_MUL;
    end else begin
      add_state_r  <= add_state_s;
      mul_state_r  <= mul_state_s;
      last_grant_r <= last_grant_s;
    end
  end

  // Write strobe, written pulses, write data and debug counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_res_r    <= {FIFO_OUT_WIDTH{1'b0}};
      w_en_out_r    <= 1'b0;
      sum_written_r <= 1'b0;
      mul_written_r <= 1'b0;
      add_cnt_r     <= {CNT_WIDTH{1'b0}};
      mul_cnt_r     <= {CNT_WIDTH{1'b0}};
    end else begin
      w_en_out_r    <= grant_a_s | grant_m_s;
      sum_written_r <= grant_a_s;
      mul_written_r <= grant_m_s;
      // Data holds its last written value when nothing is granted.
      if (grant_a_s) begin
        fifo_res_r <= result_add;
        add_cnt_r  <= add_cnt_r + CNT_WIDTH'(1);
      end else if (grant_m_s) begin
        fifo_res_r <= result_mul;
        mul_cnt_r  <= mul_cnt_r + CNT_WIDTH'(1);
      end else begin
        fifo_res_r <= fifo_res_r;
      end
    end
  end

  assign fifo_res    = fifo_res_r;
  assign w_en_out    = w_en_out_r;
  assign sum_written = sum_written_r;
  assign mul_written = mul_written_r;
  assign add_cnt     = add_cnt_r;
  assign mul_cnt     = mul_cnt_r;

endmodule

// File: tb/tb_alu_out_arbiter.sv
// Directed self-checking bench for alu_out_arbiter; a second instance with a
// 3-bit counter exercises counter wrap-around in a short run.
module tb_alu_out_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid_res = 1'b0;
  logic        m_valid_res = 1'b0;
  logic [24:0] result_add = 25'h0;
  logic [24:0] result_mul = 25'h0;
  logic        ready_f_res = 1'b0;
  logic [24:0] fifo_res;
  logic        w_en_out;
  logic        sum_written;
  logic        mul_written;
  logic [15:0] add_cnt;
  logic [15:0] mul_cnt;

  logic [24:0] fifo_res_w3;
  logic        w_en_out_w3;
  logic        sum_written_w3;
  logic        mul_written_w3;
  logic [2:0]  add_cnt_w3;
  logic [2:0]  mul_cnt_w3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_out_arbiter #(.FIFO_OUT_WIDTH(25), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .a_valid_res(a_valid_res), .m_valid_res(m_valid_res),
    .result_add(result_add), .result_mul(result_mul), .ready_f_res(ready_f_res),
    .fifo_res(fifo_res), .w_en_out(w_en_out), .sum_written(sum_written),
    .mul_written(mul_written), .add_cnt(add_cnt), .mul_cnt(mul_cnt)
  );

  alu_out_arbiter #(.FIFO_OUT_WIDTH(25), .CNT_WIDTH(3)) dut_w3 (
    .clk(clk), .rst(rst), .a_valid_res(a_valid_res), .m_valid_res(m_valid_res),
    .result_add(result_add), .result_mul(result_mul), .ready_f_res(ready_f_res),
    .fifo_res(fifo_res_w3), .w_en_out(w_en_out_w3), .sum_written(sum_written_w3),
    .mul_written(mul_written_w3), .add_cnt(add_cnt_w3), .mul_cnt(mul_cnt_w3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_valid_res = 1'b0;
    m_valid_res = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic wen, input logic sw,
                         input logic mw);
    chk({tag, ".w_en"}, {31'd0, w_en_out}, {31'd0, wen});
    chk({tag, ".sum_wr"}, {31'd0, sum_written}, {31'd0, sw});
    chk({tag, ".mul_wr"}, {31'd0, mul_written}, {31'd0, mw});
  endtask

  logic [24:0] a_word;
  logic [24:0] m_word;
  int          a_issued;
  int          m_issued;
  logic        exp_add;

  initial begin
    // Reset values
    #1 rst = 1'b1;
    #2;
    chk_out("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.fifo", {7'd0, fifo_res}, 32'h0);
    chk("rst.add_cnt", {16'd0, add_cnt}, 32'd0);
    chk("rst.mul_cnt", {16'd0, mul_cnt}, 32'd0);
    tick();
    rst = 1'b0;

    // Single adder write, then valid held high for 4 more cycles
    a_valid_res = 1'b1;
    result_add  = 25'h0A_1234;
    ready_f_res = 1'b1;
    tick();
    chk_out("add1", 1'b1, 1'b1, 1'b0);
    chk("add1.fifo", {7'd0, fifo_res}, 32'h0A_1234);
    chk("add1.add_cnt", {16'd0, add_cnt}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("hold", 1'b0, 1'b0, 1'b0);
      chk("hold.fifo", {7'd0, fifo_res}, 32'h0A_1234);
      chk("hold.add_cnt", {16'd0, add_cnt}, 32'd1);
    end
    a_valid_res = 1'b0;
    tick();

    // Both channels re-requesting: strict alternation starting with ADD
    do_reset();
    a_word = 25'h0B_0001;
    m_word = 25'h0C_0001;
    result_add  = a_word;
    result_mul  = m_word;
    a_valid_res = 1'b1;
    m_valid_res = 1'b1;
    a_issued = 1;
    m_issued = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_add = (k % 2 == 0);
      chk_out($sformatf("rr%0d", k), 1'b1, exp_add, !exp_add);
      chk($sformatf("rr%0d.fifo", k), {7'd0, fifo_res}, {7'd0, exp_add ? a_word : m_word});
      if (exp_add) begin
        a_valid_res = 1'b0;
        if (!m_valid_res && m_issued < 3) begin
          m_word = m_word + 25'd1;
          result_mul = m_word;
          m_valid_res = 1'b1;
          m_issued++;
        end
      end else begin
        m_valid_res = 1'b0;
        if (!a_valid_res && a_issued < 3) begin
          a_word = a_word + 25'd1;
          result_add = a_word;
          a_valid_res = 1'b1;
          a_issued++;
        end
      end
    end
    tick();
    chk_out("rr_idle", 1'b0, 1'b0, 1'b0);
    chk("rr.add_cnt", {16'd0, add_cnt}, 32'd3);
    chk("rr.mul_cnt", {16'd0, mul_cnt}, 32'd3);

    // FIFO full stall on a pending multiplier result
    do_reset();
    result_mul  = 25'h1F_00AA;
    m_valid_res = 1'b1;
    ready_f_res = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("stall", 1'b0, 1'b0, 1'b0);
    end
    ready_f_res = 1'b1;
    tick();
    chk_out("unstall", 1'b1, 1'b0, 1'b1);
    chk("unstall.fifo", {7'd0, fifo_res}, 32'h1F_00AA);
    chk("unstall.mul_cnt", {16'd0, mul_cnt}, 32'd1);
    m_valid_res = 1'b0;
    tick();

    // Reset asserted while a write strobe is high
    result_mul  = 25'h15_5555;
    m_valid_res = 1'b1;
    tick();
    chk_out("prerst", 1'b1, 1'b0, 1'b1);
    chk("prerst.mul_cnt", {16'd0, mul_cnt}, 32'd2);
    rst = 1'b1;
    #1;
    chk_out("midrst", 1'b0, 1'b0, 1'b0);
    chk("midrst.mul_cnt", {16'd0, mul_cnt}, 32'd0);
    chk("midrst.add_cnt", {16'd0, add_cnt}, 32'd0);
    #1 rst = 1'b0;
    tick();
    chk_out("postrst", 1'b1, 1'b0, 1'b1);
    chk("postrst.fifo", {7'd0, fifo_res}, 32'h15_5555);
    chk("postrst.mul_cnt", {16'd0, mul_cnt}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_out("postrst_hold", 1'b0, 1'b0, 1'b0);
    end
    chk("postrst_hold.mul_cnt", {16'd0, mul_cnt}, 32'd1);

    // Counter wrap on the narrow-counter instance
    do_reset();
    for (int i = 0; i < 8; i++) begin
      result_add  = 25'h100 + 25'(i);
      a_valid_res = 1'b1;
      tick();
      chk($sformatf("wrap%0d.w_en", i), {31'd0, w_en_out_w3}, 32'd1);
      chk($sformatf("wrap%0d.cnt16", i), {16'd0, add_cnt}, 32'(i + 1));
      chk($sformatf("wrap%0d.cnt3", i), {29'd0, add_cnt_w3}, 32'((i + 1) % 8));
      a_valid_res = 1'b0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_out_arbiter.md
Name: alu_out_arbiter

Overview:
- Round-robin arbiter that shares the single FIFO_OUT write port between the ALU adder and multiplier result channels.
- Issues a one-cycle registered write strobe with the selected 25-bit {ID, result} word.
- Returns a one-cycle "written" pulse to the granted ALU unit.
- Locks out a channel until its valid falls, so no result is written twice. Keeps per-channel write counters for debug and coverage.

Parameters:
- FIFO_OUT_WIDTH, 25, width of one FIFO_OUT entry (8-bit ID plus result)
- CNT_WIDTH, 16, width of each per-channel write counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- a_valid_res  input  1  adder result valid; held high until sum_written is seen
- m_valid_res  input  1  multiplier result valid; held high until mul_written is seen
- result_add  input  FIFO_OUT_WIDTH  adder {ID, result} word
- result_mul  input  FIFO_OUT_WIDTH  multiplier {ID, result} word
- ready_f_res  input  1  FIFO_OUT can accept a write this cycle (not full)
- fifo_res  output  FIFO_OUT_WIDTH  registered write data to FIFO_OUT
- w_en_out  output  1  registered one-cycle FIFO_OUT write strobe
- sum_written  output  1  one-cycle pulse: adder result written
- mul_written  output  1  one-cycle pulse: multiplier result written
- add_cnt  output  CNT_WIDTH  number of adder results written, wraps
- mul_cnt  output  CNT_WIDTH  number of multiplier results written, wraps

Behaviour:
- Reset values (async on rst=1):
  - fifo_res=0, w_en_out=0, sum_written=0, mul_written=0, add_cnt=0, mul_cnt=0.
  - Both channel FSMs = READY.
  - last_grant = MUL, so ADD wins the first tie.
- Per-channel FSM (ADD and MUL, identical):
  - READY -> HOLD on the clock edge that grants the channel.
  - HOLD -> READY on the first edge where that channel's valid is sampled 0.
  - A channel in HOLD is never eligible, even if valid stays high.
- Eligibility: elig_a = a_valid_res & (ADD==READY); elig_m = m_valid_res & (MUL==READY).
- Grant decision (combinational from sampled inputs, applied at the edge), only when ready_f_res=1:
  - only elig_a: grant ADD
  - only elig_m: grant MUL
  - both: grant the channel not equal to last_grant
  - neither, or ready_f_res=0: no grant
- On a grant at edge T, in the same edge:
  - fifo_res <= selected word; w_en_out <= 1
  - granted written pulse <= 1; other written output <= 0
  - granted channel -> HOLD; last_grant <= granted channel
  - granted counter increments by 1, wrapping from 2^CNT_WIDTH-1 to 0
- Latency:
  - valid & ready & eligible sampled at edge T -> w_en_out and written high for cycle T..T+1 exactly.
  - Both fall at edge T+1 unless a new grant occurs.
- No grant:
  - w_en_out=0 and both written outputs 0.
  - fifo_res holds its last written value; not cleared.
- Throughput:
  - Writes may be back-to-back when the grant alternates channels. Max 1 write per cycle.
  - The same channel can be written at most every other cycle: grant, then HOLD until valid low, then a new valid.
- Simultaneous events:
  - A valid falling and rising again in consecutive cycles is handled. HOLD clears on the low sample; the next high is a new request.
  - HOLD->READY and a grant never occur on the same edge for one channel.
- ready_f_res falling while a valid is pending: the request waits; no state change. Grant resumes when ready_f_res returns to 1.
- Reset mid-operation:
  - A pending w_en_out / written pulse is cancelled immediately.
  - HOLD flags, counters and last_grant are restored to their reset values.
- Fairness: with both channels continuously re-requesting, grants strictly alternate. No channel waits more than one write.

Test Plan:
- Reset then a_valid_res=1, result_add=25'h0A_1234, ready_f_res=1 -> next cycle w_en_out=1, fifo_res=25'h0A_1234, sum_written=1 for 1 cycle, add_cnt=1.
- a_valid_res held high 4 cycles after the grant (ALU slow to drop) -> exactly one w_en_out pulse, add_cnt stays 1.
- Both valids rise together after reset, each dropping the cycle after its written pulse and re-asserting 1 cycle later, for 6 writes -> grant order ADD, MUL, ADD, MUL, ADD, MUL; add_cnt=3, mul_cnt=3.
- m_valid_res=1 with ready_f_res=0 for 5 cycles, then ready_f_res=1 -> no w_en_out during the stall; single write with fifo_res=result_mul one cycle after ready rises.
- rst asserted in the cycle w_en_out=1 -> w_en_out, mul_written and counters 0 immediately; after release, the pending valid is granted once.
- Preload add_cnt to 16'hFFFF via 65535 writes (or a forced check) -> next adder write gives add_cnt=0.
